counter_ctrl: RTL

Sequencing controller that drives the EN/CLR inputs of the 8-bit `counter` block and watches its `counter`/`OV` outputs. On a start command it clears the counter, enables counting until the counter value equals a programmed target, then pulses `done`. It also counts overflow wraps during a run. It replaces hand-written testbench stimulus with a reusable initiator for the counter interface.

---
 rtl/counter_ctrl_pkg.sv | 17 +
 rtl/counter_ctrl_stall.sv | 47 ++++
 rtl/counter_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter_ctrl sequencing controller.
// The optional stall monitor is selected with the COUNTER_CTRL_STALL_EN macro.
package counter_ctrl_pkg;

    localparam int CC_WIDTH       = 8;
    localparam int CC_OVF_WIDTH   = 4;
    localparam int CC_STALL_LIMIT = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } cc_state_t;

endpackage

// File: rtl/counter_ctrl_stall.sv
// stall_monitor: flags when the counter value has not changed for STALL_LIMIT
// consecutive qualified (run_i) cycles. Only instantiated under COUNTER_CTRL_STALL_EN.
module stall_monitor
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = CC_WIDTH,
    parameter int STALL_LIMIT = CC_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             run_i,
    output logic             stall_o
);

    localparam int CW = $clog2(STALL_LIMIT + 1);

    logic [WIDTH-1:0] last_q;
    logic [CW-1:0]    same_q;
    logic [CW-1:0]    same_d;

    // same_d counts the current cycle: the first qualified cycle is 1, so the
    // STALL_LIMIT-th consecutive unchanged cycle raises stall_o.
    always_comb begin
        same_d = '0;
        if (run_i) begin
            if ((same_q != '0) && (counter_i == last_q)) begin
                same_d = (same_q == CW'(STALL_LIMIT)) ? same_q : same_q + CW'(1);
            end else begin
                same_d = CW'(1);
            end
        end
    end

    assign stall_o = run_i && (same_d == CW'(STALL_LIMIT));

    always_ff @(posedge clk) begin
        if (!Reset) begin
            last_q <= '0;
            same_q <= '0;
        end else begin
            last_q <= counter_i;
            same_q <= same_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/clear sequencer for the 8-bit counter block, with an
// overflow tally and an optional stall monitor (macro COUNTER_CTRL_STALL_EN).
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = CC_WIDTH,
    parameter int OVF_WIDTH   = CC_OVF_WIDTH,
    parameter int STALL_LIMIT = CC_STALL_LIMIT
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clr_req,
    input  logic [WIDTH-1:0]     target,
    input  logic [WIDTH-1:0]     counter,
    input  logic                 OV,
    output logic                 EN,
    output logic                 CLR,
    output logic                 busy,
    output logic                 done,
    output logic [OVF_WIDTH-1:0] ovf_count,
    output logic                 err
);

    cc_state_t            state_q, state_d;
    logic                 run_after_clr_q, run_after_clr_d;
    logic                 launch;
    logic [WIDTH-1:0]     tgt_q;
    logic [OVF_WIDTH-1:0] ovf_q;
    logic                 stall;
    logic                 stall_hit;
    logic                 at_last;

    // The counter increments on the edge that leaves RUN, so stop one short.
    assign at_last   = (counter == tgt_q - WIDTH'(1));
    assign stall_hit = (state_q == S_RUN) && stall && !clr_req;

    // NOTE: Reset is synchronous; it only takes effect on a clk edge.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q         <= S_IDLE;
            run_after_clr_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            run_after_clr_q <= run_after_clr_d;
        end
    end

    // NOTE: every output of a comb block gets a default first, so no path infers a latch.
    always_comb begin
        state_d         = state_q;
        run_after_clr_d = run_after_clr_q;
        launch          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d         = S_CLEAR;
                    run_after_clr_d = 1'b0;
                end else if (start) begin
                    state_d         = S_CLEAR;
                    run_after_clr_d = 1'b1;
                    launch          = 1'b1;
                end
            end
            S_CLEAR: state_d = (run_after_clr_q && !clr_req) ? S_RUN : S_IDLE;
            S_RUN: begin
                if (clr_req) begin
                    state_d         = S_CLEAR;
                    run_after_clr_d = 1'b0;
                end else if (stall || at_last) begin
                    state_d = S_DONE;
                end else if (stop) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (clr_req) begin
                    state_d         = S_CLEAR;
                    run_after_clr_d = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clr_req) begin
                    state_d         = S_CLEAR;
                    run_after_clr_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        EN   = 1'b0;
        CLR  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CLEAR: begin
                CLR  = 1'b1;
                busy = 1'b1;
            end
            S_RUN: begin
                EN   = 1'b1;
                busy = 1'b1;
            end
            S_HOLD:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // OV trails the wrapping increment by a cycle, hence DONE also counts.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            tgt_q <= '0;
            ovf_q <= '0;
        end else if (launch) begin
            tgt_q <= target;
            ovf_q <= '0;
        end else if (OV && ((state_q == S_RUN) || (state_q == S_DONE)) && (ovf_q != '1)) begin
            ovf_q <= ovf_q + OVF_WIDTH'(1);
        end
    end

    assign ovf_count = ovf_q;

`ifdef COUNTER_CTRL_STALL_EN
    logic err_q;

    stall_monitor #(
        .WIDTH      (WIDTH),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall (
        .clk      (clk),
        .Reset    (Reset),
        .counter_i(counter),
        .run_i    (state_q == S_RUN),
        .stall_o  (stall)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if (launch) begin
            err_q <= 1'b0;
        end else if (stall_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_stall_limit;

    assign stall              = 1'b0;
    assign unused_stall_limit = |STALL_LIMIT;
    assign err                = stall_hit;
`endif

endmodule
